// File: rtl/forwarding_scoreboard_if.sv
// Operand-forwarding bus between the EX stage (master) and the forwarding scoreboard (slave).
interface forwarding_scoreboard_if #(
  parameter int NUM_SRC    = 3,
  parameter int REG_ADDR_W = 4,
  parameter int DEPTH      = 2
);
  localparam int SEL_W = $clog2(DEPTH + 1);

  logic                          fwd_en;
  logic                          advance;
  logic                          flush;
  logic                          issue_valid;
  logic [REG_ADDR_W-1:0]         issue_dest;
  logic                          issue_wb_en;
  logic                          issue_mem_rd;
  logic [NUM_SRC*REG_ADDR_W-1:0] src_addr;
  logic [NUM_SRC-1:0]            src_used;
  logic [NUM_SRC*SEL_W-1:0]      sel_src;
  logic                          hazard_stall;

  modport master (
    output fwd_en, advance, flush, issue_valid, issue_dest, issue_wb_en,
           issue_mem_rd, src_addr, src_used,
    input  sel_src, hazard_stall
  );

  modport slave (
    input  fwd_en, advance, flush, issue_valid, issue_dest, issue_wb_en,
           issue_mem_rd, src_addr, src_used,
    output sel_src, hazard_stall
  );
endinterface

// File: rtl/forwarding_scoreboard.sv
// Forwarding/hazard unit: shift-tracker of in-flight writers after EX, operand selects and stall.
// Optional FWD_SCOREBOARD_STATS_EN adds saturating fwd_count / stall_count outputs.
module forwarding_scoreboard #(
  parameter int NUM_SRC    = 3,
  parameter int REG_ADDR_W = 4,
  parameter int DEPTH      = 2
) (
  input  logic                   clk,
  input  logic                   rst_n,
  forwarding_scoreboard_if.slave sb
`ifdef FWD_SCOREBOARD_STATS_EN
  ,
  output logic [15:0]            fwd_count,
  output logic [15:0]            stall_count
`endif
);
  localparam int SEL_W = $clog2(DEPTH + 1);

  logic [DEPTH-1:0]              valid_r;
  logic [DEPTH-1:0]              wb_en_r;
  logic [REG_ADDR_W-1:0]         dest_r [DEPTH];
  // Only the MEM-stage load flag can cause a load-use hazard, so older entries drop it.
  logic                          mem_rd0_r;

  logic [NUM_SRC-1:0][DEPTH-1:0] match_s;
  logic [NUM_SRC*SEL_W-1:0]      sel_s;
  logic                          stall_s;
  logic                          enter_s;

  for (genvar k = 0; k < NUM_SRC; k++) begin : g_src
    for (genvar i = 0; i < DEPTH; i++) begin : g_ent
      assign match_s[k][i] = valid_r[i] & wb_en_r[i] & sb.src_used[k] &
                             (dest_r[i] == sb.src_addr[k*REG_ADDR_W +: REG_ADDR_W]);
    end
  end

  // Select and stall: walk oldest to youngest so the youngest matching writer wins.
  always_comb begin
    sel_s   = '0;
    stall_s = 1'b0;
    for (int k = 0; k < NUM_SRC; k++) begin
      for (int i = DEPTH - 1; i >= 0; i--) begin
        sel_s[k*SEL_W +: SEL_W] = (match_s[k][i] & sb.fwd_en) ? SEL_W'(i + 1)
                                                                : sel_s[k*SEL_W +: SEL_W];
      end
      stall_s = stall_s | (sb.fwd_en ? (match_s[k][0] & mem_rd0_r) : (|match_s[k]));
    end
  end

  assign enter_s         = sb.issue_valid & ~sb.flush & ~stall_s;
  assign sb.sel_src      = sel_s;
  assign sb.hazard_stall = stall_s;

  // Writer tracker: shifts on advance; a stalled, flushed or empty EX slot enters as a bubble.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      valid_r   <= '0;
      wb_en_r   <= '0;
      mem_rd0_r <= 1'b0;
      dest_r    <= '{default: '0};
    end else if (sb.advance) begin
      for (int i = 1; i < DEPTH; i++) begin
        valid_r[i] <= valid_r[i-1];
        wb_en_r[i] <= wb_en_r[i-1];
        dest_r[i]  <= dest_r[i-1];
      end
      valid_r[0] <= enter_s;
      wb_en_r[0] <= enter_s & sb.issue_wb_en;
      mem_rd0_r  <= enter_s & sb.issue_mem_rd;
      dest_r[0]  <= sb.issue_dest;
    end
  end

`ifdef FWD_SCOREBOARD_STATS_EN
  logic [15:0] fwd_count_r;
  logic [15:0] stall_count_r;

  // Saturating event counters, updated only on advancing edges.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      fwd_count_r   <= 16'h0000;
      stall_count_r <= 16'h0000;
    end else if (sb.advance) begin
      if (stall_s && (stall_count_r != 16'hFFFF)) begin
        stall_count_r <= stall_count_r + 16'h0001;
      end
      if (!stall_s && (|sel_s) && (fwd_count_r != 16'hFFFF)) begin
        fwd_count_r <= fwd_count_r + 16'h0001;
      end
    end
  end

  assign fwd_count   = fwd_count_r;
  assign stall_count = stall_count_r;
`endif
endmodule
